id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register sitting between the register file read ports and the ALU.
//  - Captures the two register-file read operands, the decode fields and the control bits.
//  - Bypasses same-cycle writeback data around the register file.
//  - Detects load-use hazards and inserts a single bubble, stalling IF/ID.
//  - Supports a downstream hold and a branch flush.
// PARAMETERS
//  DATA_W  32  operand / immediate width
//  CTRL_W  8   opaque EX/MEM/WB control bundle width, passed through unmodified
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  flush         in   1       kill the instruction entering EX (branch/jump taken)
//  ex_hold       in   1       downstream stall: hold all EX outputs
//  id_valid      in   1       decode slot holds a real instruction
//  id_rs         in   5       source register 1 address (drives read_reg1)
//  id_rt         in   5       source register 2 address (drives read_reg2)
//  id_dest       in   5       destination register after RegDst selection
//  id_rs_data    in   DATA_W  read_data1 from register file
//  id_rt_data    in   DATA_W  read_data2 from register file
//  id_imm        in   DATA_W  sign/zero-extended immediate
//  id_ctrl       in   CTRL_W  control bundle
//  id_mem_read   in   1       instruction is a load
//  id_reg_write  in   1       instruction writes a register
//  wb_reg_write  in   1       writeback enable (same signal as register file RegWrite)
//  wb_write_reg  in   5       writeback address
//  wb_write_data in   DATA_W  writeback data
//  ex_valid      out  1       EX slot holds a real instruction
//  ex_rs, ex_rt, ex_dest  out  5  latched register addresses (used by the EX forwarding unit)
//  ex_rs_data, ex_rt_data out  DATA_W  latched operands
//  ex_imm        out  DATA_W  latched immediate
//  ex_ctrl       out  CTRL_W  latched control bundle
//  ex_mem_read   out  1       latched load flag
//  ex_reg_write  out  1       latched write flag, forced 0 whenever ex_valid=0
//  id_stall      out  1       combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  Reset
//   - All registered outputs go to 0; ex_valid=0, so id_stall=0.
//  Bypass (combinational, before capture)
//   - rs_byp = (id_rs==0) ? 0
//       : (wb_reg_write && wb_write_reg==id_rs && wb_write_reg!=0) ? wb_write_data
//       : id_rs_data
//   - rt_byp uses the same rule with id_rt.
//   - Covers the register file's posedge-write / old-value read race.
//  Hazard (combinational)
//   - hz = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & (ex_dest==id_rs | ex_dest==id_rt)
//   - id_stall = (hz | ex_hold) & ~flush
//  Per rising edge, in priority order
//   1. reset: clear all state.
//   2. flush: ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; the other fields are don't-care.
//      flush overrides ex_hold and hz.
//   3. ex_hold: all EX outputs keep their values.
//   4. hz: insert a bubble.
//      - ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0.
//      - The ID instruction is held by id_stall and re-presented next cycle.
//      - The bubble clears hz, so a stall lasts exactly 1 cycle per load-use pair.
//   5. else: capture id_* (using rs_byp/rt_byp) into ex_*.
//      - ex_valid<=id_valid.
//      - ex_reg_write<=id_reg_write&id_valid; ex_mem_read<=id_mem_read&id_valid.
//  Latency and register $0
//   - Latency: 1 cycle, ID to EX.
//   - Register $0 is never a hazard and is never bypassed; its operand is always 0.
//  Simultaneous events
//   - A held instruction keeps its operands.
//   - Bypass applies only on the capture edge.
//   - A WB write landing during a hold is recovered by the EX forwarding unit, not here.
// TESTING
//  1. Reset, then id_valid=1, rs=20, rt=21, data=16/32
//     -> next cycle ex_valid=1, ex_rs_data=16, ex_rt_data=32, id_stall=0.
//  2. wb_reg_write=1, wb_write_reg=9, wb_write_data=0xABCD, id_rs=9, id_rs_data=64
//     -> ex_rs_data=0xABCD; same case with wb_write_reg=0 -> ex_rs_data=64.
//  3. Load (mem_read=1, dest=8) in EX, next ID instruction rs=8
//     -> id_stall=1 one cycle, ex_valid=0 bubble, then the instruction enters EX; no second stall.
//  4. Same load-use pair plus flush=1
//     -> id_stall=0, ex_valid=0, ex_reg_write=0.
//  5. ex_hold=1 for 3 cycles while id_* changes
//     -> ex_* constant, id_stall=1; release -> the new ID instruction is captured.
//  6. id_rs=0 with id_rs_data=0x55 and a matching WB write to 0
//     -> ex_rs_data=0; reset asserted mid-stall -> ex_valid=0, id_stall=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands, decode fields and control bits, bypasses
// same-cycle writeback data, and inserts one bubble per load-use hazard.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic              id_stall
);

    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        dest_q, dest_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mem_read_q, mem_read_d;
    logic              reg_write_q, reg_write_d;
    logic              hz;
    logic [DATA_W-1:0] rs_byp, rt_byp;

    // Register file writes on the same edge it is read, so forward the WB value here.
    function automatic logic [DATA_W-1:0] bypass(input logic [4:0]        ra,
                                                 input logic [DATA_W-1:0] rd);
        if (ra == 5'd0) begin
            return '0;
        end else if (wb_reg_write && (wb_write_reg == ra)) begin
            return wb_write_data;
        end else begin
            return rd;
        end
    endfunction

    always_comb begin
        rs_byp   = bypass(id_rs, id_rs_data);
        rt_byp   = bypass(id_rt, id_rt_data);
        hz       = id_valid & valid_q & mem_read_q & (dest_q != 5'd0) &
                   ((dest_q == id_rs) | (dest_q == id_rt));
        id_stall = (hz | ex_hold) & ~flush;

        valid_d     = valid_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        dest_d      = dest_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;

        if (flush || (!ex_hold && hz)) begin
            // Kill or bubble: only the qualifying bits matter, payload is left as-is.
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end else if (!ex_hold) begin
            valid_d     = id_valid;
            rs_d        = id_rs;
            rt_d        = id_rt;
            dest_d      = id_dest;
            rs_data_d   = rs_byp;
            rt_data_d   = rt_byp;
            imm_d       = id_imm;
            ctrl_d      = id_ctrl;
            mem_read_d  = id_mem_read & id_valid;
            reg_write_d = id_reg_write & id_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dest_q      <= dest_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_dest      = dest_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the EX state per edge,
// the prediction is queued when stimulus is driven and compared after the edge.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 8;

    logic              clock = 1'b0;
    logic              reset, flush, ex_hold, id_valid;
    logic [4:0]        id_rs, id_rt, id_dest, wb_write_reg;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, wb_write_data;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read, id_reg_write, wb_reg_write;
    logic              ex_valid, ex_mem_read, ex_reg_write, id_stall;
    logic [4:0]        ex_rs, ex_rt, ex_dest;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    typedef struct packed {
        logic              valid, rw, mr, known;
        logic [4:0]        rs, rt, dest;
        logic [DATA_W-1:0] rsd, rtd, imm;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t m = '0;
    logic m_init = 1'b0;
    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ex_hold(ex_hold),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .id_stall(id_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_byp(input logic [4:0] ra,
                                                  input logic [DATA_W-1:0] rd);
        if (ra == 5'd0) return '0;
        if (wb_reg_write && wb_write_reg == ra && wb_write_reg != 5'd0) return wb_write_data;
        return rd;
    endfunction

    task automatic predict(output exp_t nx, output logic stall);
        logic hz;
        hz = id_valid && m.valid && m.mr && (m.dest != 5'd0) &&
             ((m.dest == id_rs) || (m.dest == id_rt));
        stall = (hz || ex_hold) && !flush;
        nx = m;
        if (reset) begin
            nx = '0;
            nx.known = 1'b1;
        end else if (flush || (!ex_hold && hz)) begin
            nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.known = 1'b0;
        end else if (!ex_hold) begin
            nx.valid = id_valid;
            nx.rw    = id_reg_write & id_valid;
            nx.mr    = id_mem_read & id_valid;
            nx.rs    = id_rs;
            nx.rt    = id_rt;
            nx.dest  = id_dest;
            nx.rsd   = ref_byp(id_rs, id_rs_data);
            nx.rtd   = ref_byp(id_rt, id_rt_data);
            nx.imm   = id_imm;
            nx.ctrl  = id_ctrl;
            nx.known = 1'b1;
        end
    endtask

    task automatic compare_ex(input exp_t e);
        check("ex_valid", 32'(ex_valid), 32'(e.valid));
        check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        if (e.known) begin
            check("ex_rs", 32'(ex_rs), 32'(e.rs));
            check("ex_rt", 32'(ex_rt), 32'(e.rt));
            check("ex_dest", 32'(ex_dest), 32'(e.dest));
            check("ex_rs_data", ex_rs_data, e.rsd);
            check("ex_rt_data", ex_rt_data, e.rtd);
            check("ex_imm", ex_imm, e.imm);
            check("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        end
    endtask

    task automatic step();
        exp_t nx, got;
        logic st;
        #1;
        predict(nx, st);
        if (m_init) check("id_stall", 32'(id_stall), 32'(st));
        sb_q.push_back(nx);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        compare_ex(got);
        m = got;
        m_init = 1'b1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] dest, input logic [31:0] rsd,
                            input logic [31:0] rtd, input logic mr, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
        id_rs_data = rsd; id_rt_data = rtd; id_mem_read = mr; id_reg_write = rw;
        id_imm = $urandom; id_ctrl = 8'($urandom);
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] wr, input logic [31:0] wd);
        wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'd0);
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Plain capture
        drive_id(1'b1, 5'd20, 5'd21, 5'd3, 32'd16, 32'd32, 1'b0, 1'b1);
        step();
        // WB bypass on rs, then a non-matching WB to $0, then bypass on rt
        drive_id(1'b1, 5'd9, 5'd4, 5'd5, 32'd64, 32'd7, 1'b0, 1'b1);
        drive_wb(1'b1, 5'd9, 32'hABCD);
        step();
        drive_wb(1'b1, 5'd0, 32'hABCD);
        step();
        drive_id(1'b1, 5'd2, 5'd9, 5'd5, 32'd1, 32'd2, 1'b0, 1'b1);
        drive_wb(1'b1, 5'd9, 32'h1234);
        step();
        drive_wb(1'b0, 5'd0, 32'd0);

        // Load-use: one stall, one bubble, then capture with no second stall
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd8, 5'd3, 5'd10, 32'h11, 32'h22, 1'b0, 1'b1);
        step();
        step();
        step();

        // Same pair with flush
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd3, 5'd8, 5'd10, 32'h11, 32'h22, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Hold for 3 cycles while ID changes, then release
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 1'b0, 1'b1);
        step();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'(i + 11), 5'(i + 14), 5'(i + 17), 32'(i), 32'(i + 100),
                     1'b0, 1'b1);
            step();
        end
        ex_hold = 1'b0;
        step();

        // $0 is never bypassed
        drive_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h55, 32'h55, 1'b0, 1'b1);
        drive_wb(1'b1, 5'd0, 32'hDEAD);
        step();
        drive_wb(1'b0, 5'd0, 32'd0);

        // Reset in the middle of a load-use stall
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd8, 5'd8, 5'd9, 32'h1, 32'h2, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Random traffic over a small register set to provoke hazards and bypasses
        for (int i = 0; i < 400; i++) begin
            drive_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
            drive_wb(($urandom_range(0, 1) == 0), 5'($urandom_range(0, 3)), $urandom);
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 49) == 0);
            step();
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
